// File: rtl/conv_window_3x3.sv
// Streaming 3x3 sliding-window generator for a raster-order pixel stream.
// Two IMG_W-deep row delays feed a 3x3 register window; valid-convolution windows only.
module conv_window_3x3 #(
  parameter int width = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 din_vld,
  input  logic [width-1:0]     din,
  output logic [9*width-1:0]   win_data,
  output logic                 win_vld,
  output logic                 frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [width-1:0] dly1 [IMG_W];
  logic [width-1:0] dly2 [IMG_W];
  logic [width-1:0] win  [3][3];
  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;
  logic             acc;

  assign acc = ce & din_vld & ~rst;

  // Row delays and window shift together; delay outputs are read before the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        dly1[i] <= '0;
        dly2[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (acc) begin
      dly1[0] <= din;
      dly2[0] <= dly1[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        dly1[i] <= dly1[i-1];
        dly2[i] <= dly2[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= dly2[IMG_W-1];
      win[1][2] <= dly1[IMG_W-1];
      win[2][2] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (acc) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Flags use the pre-increment position of the accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_vld    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_vld    <= acc && (col_cnt >= COL_TWO) && (row_cnt >= ROW_TWO);
      frame_done <= acc && (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
    end
  end

  always_comb begin
    win_data = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_data[(r*3+c)*width +: width] = win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed bench for conv_window_3x3: a 4x4 instance for the detailed scenarios
// and a default 28x28 instance for the full-frame count.
module tb_conv_window_3x3;

  logic        clk;
  logic        rst;
  logic        ce_s, vld_s, ce_b, vld_b;
  logic [7:0]  din_s, din_b;
  logic [71:0] win_data_s, win_data_b;
  logic        win_vld_s, frame_done_s, win_vld_b, frame_done_b;

  int tests = 0;
  int fails = 0;

  conv_window_3x3 #(.width(8), .IMG_W(4), .IMG_H(4)) dut_s (
    .clk(clk), .rst(rst), .ce(ce_s), .din_vld(vld_s), .din(din_s),
    .win_data(win_data_s), .win_vld(win_vld_s), .frame_done(frame_done_s)
  );

  conv_window_3x3 #(.width(8), .IMG_W(28), .IMG_H(28)) dut_b (
    .clk(clk), .rst(rst), .ce(ce_b), .din_vld(vld_b), .din(din_b),
    .win_data(win_data_b), .win_vld(win_vld_b), .frame_done(frame_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected window whose newest pixel sits at (r,c); pixel value = base + r*w + c, mod 256.
  function automatic logic [71:0] exp_win(input int base, input int w, input int r, input int c);
    logic [71:0] res;
    int v;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v = base + (r - 2 + i) * w + (c - 2 + j);
        res[(i*3+j)*8 +: 8] = v[7:0];
      end
    end
    return res;
  endfunction

  task automatic idle_s(input string tag);
    ce_s = 1'b1; vld_s = 1'b0; din_s = 8'hEE;
    tick();
    chk({tag, "_vld"}, {71'd0, win_vld_s}, 72'd0);
    chk({tag, "_fd"},  {71'd0, frame_done_s}, 72'd0);
  endtask

  // Sends npix pixels of a 4x4 frame; optional random gaps and a ce=0 hole before pixel 11.
  task automatic frame4(input int base, input int npix, input bit gaps, input bit hole);
    int nv, nf, r, c;
    bit ev;
    nv = 0; nf = 0;
    for (int k = 0; k < npix; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) idle_s("gap");
      end
      if (hole && k == 11) begin
        for (int i = 0; i < 5; i++) begin
          ce_s = 1'b0; vld_s = 1'b1; din_s = 8'(200 + i);
          tick();
          chk("ce_hole_vld", {71'd0, win_vld_s}, 72'd0);
          chk("ce_hole_fd",  {71'd0, frame_done_s}, 72'd0);
          chk("ce_hole_hold", win_data_s, exp_win(base, 4, 2, 2));
        end
      end
      ce_s = 1'b1; vld_s = 1'b1; din_s = 8'(base + k);
      tick();
      r = k / 4; c = k % 4;
      ev = (r >= 2) && (c >= 2);
      chk("win_vld", {71'd0, win_vld_s}, {71'd0, ev});
      chk("frame_done", {71'd0, frame_done_s}, {71'd0, (k == 15)});
      if (ev) chk("win_data", win_data_s, exp_win(base, 4, r, c));
      nv += int'(win_vld_s);
      nf += int'(frame_done_s);
    end
    if (npix == 16) begin
      chk("pulses_4x4", 72'(nv), 72'd4);
      chk("fd_4x4", 72'(nf), 72'd1);
    end
  endtask

  initial begin
    int nv, nf, r, c;
    bit ev;
    rst = 1'b1;
    ce_s = 1'b0; vld_s = 1'b0; din_s = '0;
    ce_b = 1'b0; vld_b = 1'b0; din_b = '0;
    tick(); tick();
    chk("rst_data_s", win_data_s, 72'd0);
    chk("rst_vld_s", {71'd0, win_vld_s}, 72'd0);
    chk("rst_fd_s", {71'd0, frame_done_s}, 72'd0);
    chk("rst_data_b", win_data_b, 72'd0);
    rst = 1'b0;

    // 4x4 continuous, value = index
    frame4(0, 16, 1'b0, 1'b0);
    idle_s("idle1");
    idle_s("idle1b");
    chk("idle_hold", win_data_s, exp_win(0, 4, 3, 3));

    // Random din_vld gaps plus a ce=0 hole carrying 200..204
    frame4(0, 16, 1'b1, 1'b1);
    idle_s("idle2");

    // Reset mid-frame after 9 pixels, with din_vld held high during reset
    frame4(0, 9, 1'b0, 1'b0);
    rst = 1'b1; ce_s = 1'b1; vld_s = 1'b1; din_s = 8'd77;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("midrst_data", win_data_s, 72'd0);
      chk("midrst_vld", {71'd0, win_vld_s}, 72'd0);
      chk("midrst_fd", {71'd0, frame_done_s}, 72'd0);
    end
    rst = 1'b0;
    frame4(0, 16, 1'b0, 1'b0);
    idle_s("idle3");

    // Two frames back-to-back, second frame base 100
    frame4(0, 16, 1'b0, 1'b0);
    frame4(100, 16, 1'b0, 1'b0);
    idle_s("idle4");

    // Default 28x28 continuous frame
    nv = 0; nf = 0;
    ce_b = 1'b1; vld_b = 1'b1;
    for (int k = 0; k < 784; k++) begin
      din_b = k[7:0];
      tick();
      r = k / 28; c = k % 28;
      ev = (r >= 2) && (c >= 2);
      chk("big_vld", {71'd0, win_vld_b}, {71'd0, ev});
      if (ev) chk("big_data", win_data_b, exp_win(0, 28, r, c));
      if (k == 58) begin
        chk("big_first_w00", {64'd0, win_data_b[7:0]}, 72'd0);
        chk("big_first_w22", {64'd0, win_data_b[71:64]}, 72'd58);
      end
      nv += int'(win_vld_b);
      nf += int'(frame_done_b);
    end
    chk("big_last_fd", {71'd0, frame_done_b}, 72'd1);
    vld_b = 1'b0;
    tick();
    chk("big_after_vld", {71'd0, win_vld_b}, 72'd0);
    chk("big_pulses", 72'(nv), 72'd676);
    chk("big_fd_count", 72'(nf), 72'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
